// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline-side request/response handshake and the
// word-indexed strobe interface to the data memory.
// The unit under control uses the slave view; the pipeline and memory
// (or a bench standing in for them) use the master view.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);

  // pipeline request
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // pipeline response
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // stall indication
  logic              busy;

  // data memory strobe interface
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output resp_valid,
    input  resp_ready,
    output resp_rdata,
    output resp_err,
    output busy,
    output mem_address,
    output mem_write_data,
    output mem_read,
    output mem_write,
    input  mem_read_data
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req_write,
    output req_addr,
    output req_wdata,
    input  resp_valid,
    output resp_ready,
    input  resp_rdata,
    input  resp_err,
    input  busy,
    input  mem_address,
    input  mem_write_data,
    input  mem_read,
    input  mem_write,
    output mem_read_data
  );

endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: accepts single load/store requests from the
// MEM stage, converts the byte address to a word index, drives one
// strobe cycle to the negedge-acting data memory and returns exactly one
// response per request. Misaligned or out-of-range requests bypass the
// memory entirely and answer with resp_err set.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request; req_ready high
// ISSUE  | one cycle with exactly one strobe high; memory acts on negedge
// RESP   | response presented, held until resp_ready at a posedge
module mem_access_unit #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  mem_access_unit_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_is_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic [ADDR_W-1:0] w_index;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_err;

  // Word index is the byte address shifted right by two, zero-extended.
  assign w_index        = {2'b00, bus.req_addr[ADDR_W-1:2]};
  assign w_misaligned   = (bus.req_addr[1:0] != 2'b00);
  assign w_out_of_range = (w_index >= DEPTH_L);
  assign w_err          = w_misaligned | w_out_of_range;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; errored requests skip ISSUE so no strobe is ever raised.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = w_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered memory strobes and response; strobes live for exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_write    <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_is_write <= bus.req_write;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_mem_address <= w_index;
              r_mem_wdata   <= bus.req_wdata;
              r_mem_write   <= bus.req_write;
              r_mem_read    <= ~bus.req_write;
            end
          end
        end
        S_ISSUE: begin
          // The memory has already acted on the negedge inside this cycle.
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_is_write ? '0 : bus.mem_read_data;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_write_data = r_mem_wdata;
  assign bus.mem_read       = r_mem_read;
  assign bus.mem_write      = r_mem_write;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_err       = r_resp_err;
  assign bus.resp_rdata     = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a negedge-acting word memory.
module tb_mem_access_unit;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;

  logic clk;
  logic rst_n;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int n_cmp  = 0;
  int n_mis  = 0;

  // Data memory: acts on the falling edge, counts strobe cycles it sees.
  always @(negedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_address[9:0]] <= bus.mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_read) begin
      bus.mem_read_data <= mem[bus.mem_address[9:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request at the negedge; returns #1 after the accepting posedge.
  task automatic send(input logic wr, input logic [63:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int rd0, wr0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'd1000;
    mem[1] = 32'd200;
    mem[2] = 32'hFFFF_FC18;   // -1000
    bus.mem_read_data = '0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_mem_read",    bus.mem_read, 0);
    chk("rst_mem_write",   bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_resp_valid",  bus.resp_valid, 0);
    chk("rst_req_ready",   bus.req_ready, 1);
    chk("rst_busy",        bus.busy, 0);
    rst_n = 1'b1;

    // Load word 0
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b0, 64'h0, 32'h0);
    chk("ld0_mem_read",   bus.mem_read, 1);
    chk("ld0_mem_write",  bus.mem_write, 0);
    chk("ld0_mem_addr",   bus.mem_address, 0);
    chk("ld0_busy",       bus.busy, 1);
    chk("ld0_req_ready",  bus.req_ready, 0);
    chk("ld0_early_resp", bus.resp_valid, 0);
    tick;
    chk("ld0_resp_valid", bus.resp_valid, 1);
    chk("ld0_rdata",      bus.resp_rdata, 32'd1000);
    chk("ld0_err",        bus.resp_err, 0);
    chk("ld0_strobe_off", bus.mem_read, 0);
    tick;
    chk("ld0_back_idle",  bus.req_ready, 1);
    chk("ld0_resp_drop",  bus.resp_valid, 0);
    chk("ld0_rd_pulses",  rd_cnt - rd0, 1);
    chk("ld0_wr_pulses",  wr_cnt - wr0, 0);

    // Store then load at byte 0x14 (word 5)
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b1, 64'h14, 32'h1234_5678);
    chk("st_mem_write",   bus.mem_write, 1);
    chk("st_mem_read",    bus.mem_read, 0);
    chk("st_mem_addr",    bus.mem_address, 5);
    chk("st_mem_wdata",   bus.mem_write_data, 32'h1234_5678);
    tick;
    chk("st_resp_valid",  bus.resp_valid, 1);
    chk("st_rdata_zero",  bus.resp_rdata, 0);
    chk("st_err",         bus.resp_err, 0);
    tick;
    chk("st_wr_pulses",   wr_cnt - wr0, 1);
    chk("st_rd_pulses",   rd_cnt - rd0, 0);
    chk("st_mem5",        mem[5], 32'h1234_5678);
    send(1'b0, 64'h14, 32'h0);
    tick;
    chk("ld14_rdata",     bus.resp_rdata, 32'h1234_5678);
    tick;

    // Misaligned load: immediate error response, no strobes
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b0, 64'h6, 32'h0);
    chk("mis_resp_valid", bus.resp_valid, 1);
    chk("mis_err",        bus.resp_err, 1);
    chk("mis_rdata",      bus.resp_rdata, 0);
    chk("mis_mem_read",   bus.mem_read, 0);
    chk("mis_busy",       bus.busy, 1);
    tick;
    chk("mis_idle",       bus.req_ready, 1);
    chk("mis_rd_pulses",  rd_cnt - rd0, 0);
    chk("mis_wr_pulses",  wr_cnt - wr0, 0);

    // Out-of-range store to word 1024
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b1, 64'h1000, 32'hDEAD_BEEF);
    chk("oor_resp_valid", bus.resp_valid, 1);
    chk("oor_err",        bus.resp_err, 1);
    chk("oor_mem_write",  bus.mem_write, 0);
    chk("oor_addr_kept",  bus.mem_address, 5);
    tick;
    chk("oor_wr_pulses",  wr_cnt - wr0, 0);
    chk("oor_mem0",       mem[0], 32'd1000);

    // Backpressure on load of word 1; a request during busy is ignored
    bus.resp_ready = 1'b0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(1'b0, 64'h4, 32'h0);
    tick;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h8;
    bus.req_wdata = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("bp_resp_valid", bus.resp_valid, 1);
      chk("bp_rdata",      bus.resp_rdata, 32'd200);
      chk("bp_busy",       bus.busy, 1);
      chk("bp_req_ready",  bus.req_ready, 0);
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick;
    chk("bp_release_valid", bus.resp_valid, 0);
    chk("bp_release_busy",  bus.busy, 0);
    chk("bp_wr_pulses",     wr_cnt - wr0, 0);
    chk("bp_rd_pulses",     rd_cnt - rd0, 1);
    chk("bp_mem2_kept",     mem[2], 32'hFFFF_FC18);

    // Async reset in the middle of ISSUE
    send(1'b0, 64'h8, 32'h0);
    chk("ar_mem_read_pre", bus.mem_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_read",   bus.mem_read, 0);
    chk("ar_mem_write",  bus.mem_write, 0);
    chk("ar_resp_valid", bus.resp_valid, 0);
    chk("ar_busy",       bus.busy, 0);
    #3;
    rst_n = 1'b1;
    send(1'b0, 64'h8, 32'h0);
    chk("ar_reload_rd",  bus.mem_read, 1);
    chk("ar_reload_adr", bus.mem_address, 2);
    tick;
    chk("ar_reload_rdata", bus.resp_rdata, 32'hFFFF_FC18);
    chk("ar_reload_err",   bus.resp_err, 0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
